preamble_tx: RTL and testbench

PREAMBLE_TX -- requirements
Module: preamble_tx

---
 rtl/preamble_tx_pkg.sv | 34 +++
 rtl/preamble_pattern_ram.sv | 38 +++
 rtl/preamble_tx.sv | 192 +++++++++++++++++++
 tb/tb_preamble_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/preamble_tx_pkg.sv
// preamble_tx_pkg
//   Shared definitions for the preamble transmitter:
//   - state_t   : burst sequencer states (IDLE / RUN / TAIL)
//   - I_*/Q_*   : bit positions of the I and Q halves of a sample word
//   - CNT_W     : width of the repetition and tail counters
//   - pack_iq() : builds a sample word from separate I and Q values
package preamble_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  localparam int SAMPLE_W = 32;
  localparam int I_MSB    = 31;
  localparam int I_LSB    = 16;
  localparam int Q_MSB    = 15;
  localparam int Q_LSB    = 0;

  // Repetition and tail counters. REPS and TAIL_LEN are both at most 255,
  // so 8 bits always covers their 0..N-1 count range.
  localparam int CNT_W = 8;

  function automatic logic [SAMPLE_W-1:0] pack_iq(input logic [15:0] i_val,
                                                  input logic [15:0] q_val);
    logic [SAMPLE_W-1:0] w;
    w = '0;
    w[I_MSB:I_LSB] = i_val;
    w[Q_MSB:Q_LSB] = q_val;
    return w;
  endfunction

endpackage

// File: rtl/preamble_pattern_ram.sv
// preamble_pattern_ram
//   DEPTH x 32 pattern store with one synchronous write port and one
//   asynchronous (combinational) read port. The storage is not reset, so
//   contents survive bursts, aborts and resets. They are undefined until
//   they have been written.
//
// Ports
//   clk      : write clock, rising edge
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write data {I16,Q16}
//   i_raddr  : read index
//   o_rdata  : read data, combinational from i_raddr
module preamble_pattern_ram
  import preamble_tx_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/preamble_tx.sv
// preamble_tx
//   Streams a programmable preamble into a DUC. A burst sends
//   pattern[0..PERIOD-1] REPS times and then TAIL_LEN zero samples. After
//   that the block returns to IDLE and pulses done for one cycle.
//
// Handshake: duc_in_sample is always valid while busy. The DUC pulls
//   samples by asserting duc_in_strobe; a strobe at edge t consumes the
//   current sample, and the next one is presented from t+1. Without a
//   strobe the sample holds. Strobes may be asserted every cycle.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : one-cycle burst request, accepted only in IDLE
//   abort          : ends a burst at once, with no done pulse
//   pat_wr/addr/data : pattern write; accepted only in IDLE with start low
//   duc_in_strobe  : DUC consumes duc_in_sample this cycle
//   duc_in_sample  : registered sample {I[31:16],Q[15:0]}
//   duc_in_enable  : DUC chain enable, equal to busy
//   busy           : burst in progress (RUN or TAIL)
//   done           : one-cycle pulse when a burst completes normally
//   dbg_state      : current sequencer state, for observation
module preamble_tx
  import preamble_tx_pkg::*;
#(
  parameter int PERIOD   = 32,
  parameter int REPS     = 10,
  parameter int TAIL_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       pat_wr,
  input  logic [$clog2(PERIOD)-1:0]  pat_addr,
  input  logic [SAMPLE_W-1:0]        pat_data,
  input  logic                       duc_in_strobe,
  output logic [SAMPLE_W-1:0]        duc_in_sample,
  output logic                       duc_in_enable,
  output logic                       busy,
  output logic                       done,
  output state_t                     dbg_state
);

  localparam int IDX_W = $clog2(PERIOD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST_REP  = CNT_W'(REPS - 1);
  // LAST_TAIL is only used when TAIL_LEN > 0. With TAIL_LEN = 0 the TAIL
  // state is never entered.
  localparam logic [CNT_W-1:0] LAST_TAIL = (TAIL_LEN == 0) ? '0 : CNT_W'(TAIL_LEN - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_rep;
  logic [CNT_W-1:0]    r_tail;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_done;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CNT_W-1:0]    w_rep_nxt;
  logic [CNT_W-1:0]    w_tail_nxt;
  logic [SAMPLE_W-1:0] w_sample_nxt;
  logic                w_done_nxt;

  logic                w_pat_we;
  logic [IDX_W-1:0]    w_rd_addr;
  logic [SAMPLE_W-1:0] w_rd_data;

  // Writes are blocked while a burst runs and in the start cycle itself. This
  // keeps the sample loaded on start consistent with the stored pattern.
  assign w_pat_we = pat_wr && (r_state == ST_IDLE) && !start;

  // The read port always looks ahead to the sample that the next load
  // would present: pattern[0] on start or on wrap, otherwise index+1.
  assign w_rd_addr = ((r_state == ST_RUN) && (r_idx != LAST_IDX)) ? r_idx + 1'b1 : '0;

  preamble_pattern_ram #(
    .DEPTH (PERIOD),
    .AW    (IDX_W)
  ) u_pattern_ram (
    .clk     (clk),
    .i_we    (w_pat_we),
    .i_waddr (pat_addr),
    .i_wdata (pat_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_rep    <= '0;
      r_tail   <= '0;
      r_sample <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rep    <= w_rep_nxt;
      r_tail   <= w_tail_nxt;
      r_sample <= w_sample_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Every path back to IDLE clears the counters and the sample. Because of
  // this, IDLE always shows zero outputs, and the next burst starts from
  // clean counters.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_rep_nxt    = r_rep;
    w_tail_nxt   = r_tail;
    w_sample_nxt = r_sample;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_RUN;
          w_idx_nxt    = '0;
          w_rep_nxt    = '0;
          w_tail_nxt   = '0;
          w_sample_nxt = w_rd_data;
        end
      end

      ST_RUN: begin
        if (abort) begin
          w_state_nxt  = ST_IDLE;
          w_idx_nxt    = '0;
          w_rep_nxt    = '0;
          w_tail_nxt   = '0;
          w_sample_nxt = '0;
        end else if (duc_in_strobe) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (r_rep == LAST_REP) begin
              w_rep_nxt    = '0;
              w_sample_nxt = '0;
              if (TAIL_LEN == 0) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_TAIL;
                w_tail_nxt  = '0;
              end
            end else begin
              w_rep_nxt    = r_rep + 8'd1;
              w_sample_nxt = w_rd_data;
            end
          end else begin
            w_idx_nxt    = r_idx + 1'b1;
            w_sample_nxt = w_rd_data;
          end
        end
      end

      ST_TAIL: begin
        if (abort) begin
          w_state_nxt  = ST_IDLE;
          w_tail_nxt   = '0;
          w_sample_nxt = '0;
        end else if (duc_in_strobe) begin
          if (r_tail == LAST_TAIL) begin
            w_state_nxt = ST_IDLE;
            w_tail_nxt  = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_tail_nxt = r_tail + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_idx_nxt    = '0;
        w_rep_nxt    = '0;
        w_tail_nxt   = '0;
        w_sample_nxt = '0;
      end
    endcase
  end

  assign busy          = (r_state != ST_IDLE);
  assign duc_in_enable = busy;
  assign duc_in_sample = r_sample;
  assign done          = r_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_preamble_tx.sv
// tb_preamble_tx
//   Directed and random bursts against preamble_tx (PERIOD=32, REPS=2,
//   TAIL_LEN=4). The reference model holds a copy of the pattern. On each
//   accepted start it flattens the burst into an expected sample queue:
//   REPS copies of the pattern followed by TAIL_LEN zeros. Each strobe
//   consumes one queue entry. The burst ends with a done pulse when the
//   queue is used up.
module tb_preamble_tx;
  import preamble_tx_pkg::*;

  localparam int PERIOD    = 32;
  localparam int REPS      = 2;
  localparam int TAIL_LEN  = 4;
  localparam int AW        = $clog2(PERIOD);
  localparam int RUN_LEN   = PERIOD * REPS;
  localparam int BURST_LEN = RUN_LEN + TAIL_LEN;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start         = 1'b0;
  logic          abort         = 1'b0;
  logic          pat_wr        = 1'b0;
  logic [AW-1:0] pat_addr      = '0;
  logic [31:0]   pat_data      = '0;
  logic          duc_in_strobe = 1'b0;
  logic [31:0]   duc_in_sample;
  logic          duc_in_enable;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  preamble_tx #(
    .PERIOD   (PERIOD),
    .REPS     (REPS),
    .TAIL_LEN (TAIL_LEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pat_wr        (pat_wr),
    .pat_addr      (pat_addr),
    .pat_data      (pat_data),
    .duc_in_strobe (duc_in_strobe),
    .duc_in_sample (duc_in_sample),
    .duc_in_enable (duc_in_enable),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // scoreboard / reference model
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_pat [PERIOD];
  logic [31:0] exp_q [$];
  int          m_pos  = 0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          busy_seen = 0;
  int          done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (!m_busy)             return 32'(ST_IDLE);
    else if (m_pos < RUN_LEN) return 32'(ST_RUN);
    else                     return 32'(ST_TAIL);
  endfunction

  // One clock: check outputs at the falling edge, drive the inputs for
  // the next rising edge, and advance the model with those inputs.
  task automatic step(input bit s_start, input bit s_strobe, input bit s_abort,
                      input bit s_wr = 1'b0, input logic [AW-1:0] s_addr = '0,
                      input logic [31:0] s_data = '0);
    @(negedge clk);
    check("busy",   32'(busy),          32'(m_busy));
    check("enable", 32'(duc_in_enable), 32'(m_busy));
    check("sample", duc_in_sample,      m_busy ? exp_q[m_pos] : 32'h0);
    check("done",   32'(done),          32'(m_done));
    check("state",  32'(dbg_state),     exp_state());
    if (busy === 1'b1) busy_seen++;
    if (done === 1'b1) done_seen++;

    start         = s_start;
    duc_in_strobe = s_strobe;
    abort         = s_abort;
    pat_wr        = s_wr;
    pat_addr      = s_addr;
    pat_data      = s_data;

    m_done = 1'b0;
    if (!m_busy) begin
      if (s_wr && !s_start) model_pat[s_addr] = s_data;
      if (s_start) begin
        exp_q.delete();
        for (int r = 0; r < REPS; r++)
          for (int k = 0; k < PERIOD; k++) exp_q.push_back(model_pat[k]);
        for (int t = 0; t < TAIL_LEN; t++) exp_q.push_back(32'h0);
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end else if (s_abort) begin
      m_busy = 1'b0;
    end else if (s_strobe) begin
      m_pos++;
      if (m_pos == exp_q.size()) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  // mode 0: strobe every cycle, 1: every 3rd cycle, 2: random
  task automatic drain(input int mode);
    int cyc;
    bit s;
    cyc = 0;
    while (m_busy && cyc < 5000) begin
      case (mode)
        0:       s = 1'b1;
        1:       s = (cyc % 3 == 2);
        default: s = 1'($urandom_range(0, 1));
      endcase
      step(1'b0, s, 1'b0);
      cyc++;
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < PERIOD; k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, AW'(k), pack_iq(16'(k), ~16'(k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #12;
    check("rst_busy",   32'(busy),          32'h0);
    check("rst_enable", 32'(duc_in_enable), 32'h0);
    check("rst_sample", duc_in_sample,      32'h0);
    check("rst_done",   32'(done),          32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal burst, strobe every cycle
    load_ramp();
    busy_seen = 0; done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    drain(0);
    check("t035_busy_cycles", busy_seen, BURST_LEN);
    check("t035_done_count",  done_seen, 1);

    // abort and strobe in IDLE have no effect
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // strobe every 3rd cycle
    busy_seen = 0; done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    drain(1);
    check("t036_busy_cycles", busy_seen, 3 * BURST_LEN);
    check("t036_done_count",  done_seen, 1);

    // abort together with the 40th strobe, then replay
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 39; n++) step(1'b0, 1'b1, 1'b0);
    done_seen = 0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t037_no_done", done_seen, 0);
    done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    drain(2);
    check("t037_replay_done", done_seen, 1);

    // pattern writes while busy and in the start cycle are dropped
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, AW'(5), 32'hDEADBEEF);
    drain(0);
    step(1'b1, 1'b0, 1'b0, 1'b1, AW'(5), 32'hDEADBEEF);
    drain(0);

    // start during RUN is ignored
    done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    drain(0);
    check("t040_single_done", done_seen, 1);

    // random patterns, random strobes, occasional random abort
    for (int it = 0; it < 4; it++) begin
      for (int w = 0; w < 10; w++)
        step(1'b0, 1'b0, 1'b0, 1'b1, AW'($urandom_range(0, PERIOD - 1)), $urandom);
      step(1'b1, 1'b0, 1'b0);
      if (it == 2) begin
        for (int n = 0; n < int'($urandom_range(1, BURST_LEN - 1)); n++)
          step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
      end else begin
        drain(2);
      end
    end

    // asynchronous reset in the middle of TAIL
    load_ramp();
    step(1'b1, 1'b0, 1'b0);
    while (m_busy && m_pos < RUN_LEN + 1) step(1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    duc_in_strobe = 1'b0;
    #1;
    check("t039_async_busy",   32'(busy),          32'h0);
    check("t039_async_enable", 32'(duc_in_enable), 32'h0);
    check("t039_async_sample", duc_in_sample,      32'h0);
    check("t039_async_done",   32'(done),          32'h0);
    m_busy = 1'b0; m_done = 1'b0; m_pos = 0;
    done_seen = 0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("t039_no_done", done_seen, 0);
    load_ramp();
    busy_seen = 0; done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    drain(0);
    check("t039_busy_cycles", busy_seen, BURST_LEN);
    check("t039_done_count",  done_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
